// File: rtl/text_vmem_arbiter.sv
// Text-mode video memory arbiter: one single-port RAM shared by display fetch, an optional
// clear engine, host reads and a posted host-write FIFO. Clear engine: `define TEXT_VMEM_CLEAR_EN.
module text_vmem_arbiter #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] CLEAR_WORD = 16'h0700
) (
  input  logic        in_vga_clock,
  input  logic        in_reset,
  input  logic        in_disp_req,
  input  logic [12:0] in_disp_address,
  output logic [15:0] out_disp_data,
  // Host handshake: req/we/address/wdata are held stable until a one-cycle ack pulse;
  // a request is only considered while ack is low, so one req never yields two acks.
  input  logic        in_host_req,
  input  logic        in_host_we,
  input  logic [12:0] in_host_address,
  input  logic [15:0] in_host_wdata,
  output logic        out_host_ack,
  output logic [15:0] out_host_rdata,
  output logic        out_host_busy,
  output logic [12:0] out_mem_address,
  output logic        out_mem_wren,
  output logic [15:0] out_mem_wdata,
  input  logic [15:0] in_mem_rdata,
`ifdef TEXT_VMEM_CLEAR_EN
  input  logic        in_clear_start,
  output logic        out_clear_done,
`endif
  output logic [2:0]  out_dbg_state
);

  localparam int          PW            = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] FIFO_FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_DRAIN = 3'd1,
    S_RD_ISSUE = 3'd2,
    S_RD_DATA  = 3'd3
`ifdef TEXT_VMEM_CLEAR_EN
    , S_CLEAR  = 3'd4
`endif
  } state_t;

  state_t        state_q, state_d;
  logic [28:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          ack_q, disp_pend_q;
  logic [15:0]   disp_data_q, rdata_q;
  logic          fifo_empty, fifo_full;
  logic          wr_accept, rd_start, rd_issue, clr_write, fifo_pop;
  logic [28:0]   fifo_head;

  assign fifo_empty     = (count_q == '0);
  assign fifo_full      = (count_q == FIFO_FULL_CNT);
  assign fifo_head      = fifo_mem[rd_ptr_q];
  assign out_host_ack   = ack_q;
  assign out_host_rdata = rdata_q;
  assign out_disp_data  = disp_data_q;
  assign out_dbg_state  = state_q;

`ifdef TEXT_VMEM_CLEAR_EN
  logic        clear_pend_q, clear_done_q;
  logic [12:0] clear_addr_q;
  assign out_host_busy  = clear_pend_q | (state_q == S_CLEAR);
  assign out_clear_done = clear_done_q;
  assign clr_write      = (state_q == S_CLEAR) && !in_disp_req;
`else
  assign out_host_busy  = 1'b0;
  assign clr_write      = 1'b0;
`endif

  // Writes are only taken in IDLE so a read in flight keeps later writes behind it.
  assign wr_accept = in_host_req && in_host_we && !fifo_full && !ack_q && !out_host_busy
                     && (state_q == S_IDLE);
  assign rd_start  = in_host_req && !in_host_we && !ack_q && !out_host_busy
                     && (state_q == S_IDLE);
  assign rd_issue  = (state_q == S_RD_ISSUE) && !in_disp_req;

  always_comb begin
    state_d         = state_q;
    fifo_pop        = 1'b0;
    out_mem_address = '0;
    out_mem_wren    = 1'b0;
    out_mem_wdata   = '0;
    case (state_q)
      S_IDLE: begin
`ifdef TEXT_VMEM_CLEAR_EN
        if (clear_pend_q && fifo_empty) state_d = S_CLEAR;
        else
`endif
        if (rd_start) state_d = S_RD_DRAIN;
      end
      S_RD_DRAIN: if (fifo_empty) state_d = S_RD_ISSUE;
      S_RD_ISSUE: if (rd_issue) state_d = S_RD_DATA;
      S_RD_DATA:  state_d = S_IDLE;
`ifdef TEXT_VMEM_CLEAR_EN
      S_CLEAR:    if (clr_write && (clear_addr_q == 13'h1FFF)) state_d = S_IDLE;
`endif
      default:    state_d = S_IDLE;
    endcase

    // Fixed-priority RAM port: display, clear, host read, posted write.
    if (in_disp_req) begin
      out_mem_address = in_disp_address;
    end else if (clr_write) begin
`ifdef TEXT_VMEM_CLEAR_EN
      out_mem_address = clear_addr_q;
`endif
      out_mem_wren    = 1'b1;
      out_mem_wdata   = CLEAR_WORD;
    end else if (rd_issue) begin
      out_mem_address = in_host_address;
    end else if (!fifo_empty) begin
      fifo_pop        = 1'b1;
      out_mem_address = fifo_head[28:16];
      out_mem_wren    = 1'b1;
      out_mem_wdata   = fifo_head[15:0];
    end
  end

  always_ff @(posedge in_vga_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ack_q       <= 1'b0;
      disp_pend_q <= 1'b0;
      disp_data_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= wr_accept || (state_q == S_RD_DATA);
      disp_pend_q <= in_disp_req;
      if (disp_pend_q) disp_data_q <= in_mem_rdata;
      if (state_q == S_RD_DATA) rdata_q <= in_mem_rdata;
      if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (fifo_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW + 1)'(wr_accept) - (PW + 1)'(fifo_pop);
    end
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge in_vga_clock) begin
    if (wr_accept) fifo_mem[wr_ptr_q] <= {in_host_address, in_host_wdata};
  end

`ifdef TEXT_VMEM_CLEAR_EN
  always_ff @(posedge in_vga_clock or posedge in_reset) begin
    if (in_reset) begin
      clear_pend_q <= 1'b0;
      clear_done_q <= 1'b0;
      clear_addr_q <= '0;
    end else begin
      clear_done_q <= 1'b0;
      if ((state_q != S_CLEAR) && (state_d == S_CLEAR)) begin
        clear_pend_q <= 1'b0;
        clear_addr_q <= '0;
      end else if (in_clear_start && !clear_pend_q && (state_q != S_CLEAR)) begin
        clear_pend_q <= 1'b1;
      end
      if (clr_write) begin
        clear_addr_q <= clear_addr_q + 13'd1;
        if (clear_addr_q == 13'h1FFF) clear_done_q <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_text_vmem_arbiter.sv
// Self-checking bench for text_vmem_arbiter: RAM model, write scoreboard, scenario tasks.
module tb_text_vmem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        disp_req;
  logic [12:0] disp_addr;
  logic [15:0] disp_data;
  logic        host_req, host_we;
  logic [12:0] host_addr;
  logic [15:0] host_wdata, host_rdata;
  logic        host_ack, host_busy;
  logic [12:0] mem_addr;
  logic        mem_wren;
  logic [15:0] mem_wdata, mem_rdata;
  logic [2:0]  dbg_state;
`ifdef TEXT_VMEM_CLEAR_EN
  logic        clear_start, clear_done;
`endif

  int checks   = 0;
  int failures = 0;

  logic [28:0] exp_q [$];
  logic [15:0] dexp_q [$];
  logic [15:0] shadow [8192];
  logic [15:0] ram [8192];
  logic        pl_we = 1'b0;
  logic [12:0] pl_addr = '0;
  logic [15:0] pl_data = '0;
  bit          mon_en = 1'b1;
  logic [28:0] mon_exp;

  always #5 clk = ~clk;

  text_vmem_arbiter #(.FIFO_DEPTH(4), .CLEAR_WORD(16'h0700)) dut (
    .in_vga_clock    (clk),
    .in_reset        (rst),
    .in_disp_req     (disp_req),
    .in_disp_address (disp_addr),
    .out_disp_data   (disp_data),
    .in_host_req     (host_req),
    .in_host_we      (host_we),
    .in_host_address (host_addr),
    .in_host_wdata   (host_wdata),
    .out_host_ack    (host_ack),
    .out_host_rdata  (host_rdata),
    .out_host_busy   (host_busy),
    .out_mem_address (mem_addr),
    .out_mem_wren    (mem_wren),
    .out_mem_wdata   (mem_wdata),
    .in_mem_rdata    (mem_rdata),
`ifdef TEXT_VMEM_CLEAR_EN
    .in_clear_start  (clear_start),
    .out_clear_done  (clear_done),
`endif
    .out_dbg_state   (dbg_state)
  );

  // Synchronous single-port RAM: read data valid the cycle after the address.
  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (mem_wren) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Scoreboard: every host-side RAM write must match the oldest posted write.
  always @(negedge clk) begin
    if (!rst && mem_wren && mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL ram_write unexpected addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== mon_exp) begin
          failures++;
          $display("FAIL ram_write got addr=%h data=%h exp addr=%h data=%h",
                   mem_addr, mem_wdata, mon_exp[28:16], mon_exp[15:0]);
        end
      end
    end
  end

  task automatic host_write(input logic [12:0] a, input logic [15:0] d);
    bit got = 0;
    int n = 0;
    host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
    exp_q.push_back({a, d});
    shadow[a] = d;
    while (!got && n < 200) begin
      @(negedge clk);
      if (host_ack) got = 1;
      @(posedge clk); #1;
      n++;
    end
    host_req = 1'b0; host_we = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL write_ack addr=%h got no ack in 200 cycles, exp ack", a);
    end
  endtask

  task automatic host_read(input logic [12:0] a, output logic [15:0] d, output bit got);
    int n = 0;
    got = 0; d = '0;
    host_req = 1'b1; host_we = 1'b0; host_addr = a;
    while (!got && n < 200) begin
      @(negedge clk);
      if (host_ack) begin got = 1; d = host_rdata; end
      @(posedge clk); #1;
      n++;
    end
    host_req = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; disp_req = 0; disp_addr = '0; host_req = 0; host_we = 0;
    host_addr = '0; host_wdata = '0;
`ifdef TEXT_VMEM_CLEAR_EN
    clear_start = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({host_ack, host_busy, mem_wren, dbg_state} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got ack=%b busy=%b wren=%b state=%0d exp all 0",
               host_ack, host_busy, mem_wren, dbg_state);
    end
    checks++;
    if (disp_data !== 16'h0 || host_rdata !== 16'h0) begin
      failures++;
      $display("FAIL reset_data got disp=%h rdata=%h exp 0000/0000", disp_data, host_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_display;
    pl_we = 1'b1; pl_addr = 13'h0085; pl_data = 16'h1E41;
    @(posedge clk); #1;
    pl_we = 1'b0;
    disp_req = 1'b1; disp_addr = 13'h0000;
    host_write(13'h0200, 16'hBEEF);
    disp_addr = 13'h0085;
    dexp_q.push_back(16'h1E41);
    @(negedge clk);
    checks++;
    if (mem_addr !== 13'h0085 || mem_wren !== 1'b0) begin
      failures++;
      $display("FAIL disp_port got addr=%h wren=%b exp addr=0085 wren=0", mem_addr, mem_wren);
    end
    @(posedge clk); #1;
    disp_req = 1'b0; disp_addr = '0;
    @(posedge clk); #1;
    @(negedge clk);
    begin
      logic [15:0] e;
      e = dexp_q.pop_front();
      checks++;
      if (disp_data !== e) begin
        failures++;
        $display("FAIL disp_data got=%h exp=%h", disp_data, e);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (disp_data !== e) begin
        failures++;
        $display("FAIL disp_hold got=%h exp=%h", disp_data, e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [12:0] a [5];
    logic [15:0] d;
    bit got;
    for (int i = 0; i < 5; i++) begin
      a[i] = 13'(13'h0400 + i * 7 + $urandom_range(0, 6));
      host_write(a[i], 16'($urandom_range(0, 65535)));
    end
    for (int i = 0; i < 5; i += 2) begin
      host_read(a[i], d, got);
      checks++;
      if (!got || d !== shadow[a[i]]) begin
        failures++;
        $display("FAIL b2b_readback addr=%h got=%h ack=%b exp=%h", a[i], d, got, shadow[a[i]]);
      end
    end
  endtask

  task automatic test_fifo_full;
    int acks = 0;
    int n = 0;
    bit got = 0;
    disp_req = 1'b1; disp_addr = 13'h0000;
    for (int i = 0; i < 4; i++)
      host_write(13'(13'h0600 + i), 16'($urandom_range(0, 65535)));
    host_req = 1'b1; host_we = 1'b1; host_addr = 13'h0604; host_wdata = 16'h5A5A;
    exp_q.push_back({13'h0604, 16'h5A5A});
    shadow[13'h0604] = 16'h5A5A;
    repeat (8) begin
      @(negedge clk);
      if (host_ack) acks++;
      @(posedge clk); #1;
    end
    checks++;
    if (acks != 0) begin
      failures++;
      $display("FAIL fifo_full_stall got acks=%0d exp 0", acks);
    end
    disp_req = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (host_ack) got = 1;
      @(posedge clk); #1;
      n++;
    end
    host_req = 1'b0; host_we = 1'b0;
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL fifo_full_release got no ack exp ack after pop");
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_raw;
    bit got = 0;
    int n = 0;
    logic [15:0] d = '0;
    disp_req = 1'b1; disp_addr = 13'h0001;
    host_write(13'h0010, 16'h0741);
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0010;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dbg_state !== 3'd1 || host_ack !== 1'b0) begin
        failures++;
        $display("FAIL raw_drain got state=%0d ack=%b exp state=1 ack=0", dbg_state, host_ack);
      end
      @(posedge clk); #1;
    end
    disp_req = 1'b0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (host_ack) begin got = 1; d = host_rdata; end
      @(posedge clk); #1;
      n++;
    end
    host_req = 1'b0;
    checks++;
    if (!got || d !== 16'h0741) begin
      failures++;
      $display("FAIL raw_read got=%h ack=%b exp=0741", d, got);
    end
  endtask

  task automatic test_read_collision;
    host_write(13'h0321, 16'hA5C3);
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0321;
    @(posedge clk); #1;
    @(posedge clk); #1;
    disp_req = 1'b1; disp_addr = 13'h0085;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (dbg_state !== 3'd2 || mem_addr !== 13'h0085 || mem_wren !== 1'b0) begin
        failures++;
        $display("FAIL coll_hold cyc=%0d got state=%0d addr=%h exp state=2 addr=0085",
                 i, dbg_state, mem_addr);
      end
      @(posedge clk); #1;
    end
    disp_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_addr !== 13'h0321 || mem_wren !== 1'b0) begin
      failures++;
      $display("FAIL coll_issue got addr=%h wren=%b exp addr=0321 wren=0", mem_addr, mem_wren);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (host_ack !== 1'b0 || dbg_state !== 3'd3) begin
      failures++;
      $display("FAIL coll_data got ack=%b state=%0d exp ack=0 state=3", host_ack, dbg_state);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (host_ack !== 1'b1 || host_rdata !== shadow[13'h0321]) begin
      failures++;
      $display("FAIL coll_ack got ack=%b rdata=%h exp ack=1 rdata=%h",
               host_ack, host_rdata, shadow[13'h0321]);
    end
    @(posedge clk); #1;
    host_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_read;
    int bad = 0;
    disp_req = 1'b1; disp_addr = 13'h0002;
    host_write(13'h1F00, 16'h1111);
    host_write(13'h1F01, 16'h2222);
    host_req = 1'b1; host_we = 1'b0; host_addr = 13'h0010;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (dbg_state !== 3'd1) begin
      failures++;
      $display("FAIL rst_mid_drain got state=%0d exp 1", dbg_state);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({host_ack, host_busy, mem_wren, dbg_state} !== 6'b0 || disp_data !== 16'h0
        || host_rdata !== 16'h0) begin
      failures++;
      $display("FAIL rst_mid_outputs got ack=%b busy=%b wren=%b state=%0d disp=%h rdata=%h exp 0",
               host_ack, host_busy, mem_wren, dbg_state, disp_data, host_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0; host_req = 1'b0; disp_req = 1'b0;
    exp_q.delete();
    repeat (6) begin
      @(negedge clk);
      if (mem_wren || host_ack) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_mid_quiet got %0d write/ack cycles exp 0", bad);
    end
  endtask

`ifdef TEXT_VMEM_CLEAR_EN
  task automatic test_clear;
    int ca = 0;
    int n = 0;
    int dones = 0;
    int acks_busy = 0;
    int prints = 0;
    bit done_seen = 0;
    bit got = 0;
    logic [15:0] d;
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 13'h0050; host_wdata = 16'h1111;
    @(negedge clk);
    checks++;
    if (host_busy !== 1'b1) begin
      failures++;
      $display("FAIL clr_busy got=%b exp=1", host_busy);
    end
    mon_en = 1'b0;
    while (!done_seen && n < 30000) begin
      @(negedge clk);
      if (host_ack) acks_busy++;
      if (mem_wren) begin
        checks++;
        if (mem_addr !== 13'(ca) || mem_wdata !== 16'h0700) begin
          failures++;
          if (prints < 5)
            $display("FAIL clr_write got addr=%h data=%h exp addr=%h data=0700",
                     mem_addr, mem_wdata, 13'(ca));
          prints++;
        end
        ca++;
      end
      if (clear_done) begin
        done_seen = 1; dones++;
        checks++;
        if (host_busy !== 1'b0) begin
          failures++;
          $display("FAIL clr_busy_drop got=%b exp=0", host_busy);
        end
        mon_en = 1'b1;
        exp_q.push_back({13'h0050, 16'h1111});
      end
      @(posedge clk); #1;
      disp_req = ($urandom_range(0, 3) == 0);
      clear_start = (n == 100);
      n++;
    end
    disp_req = 1'b0; clear_start = 1'b0;
    checks++;
    if (!done_seen || ca != 8192 || acks_busy != 0) begin
      failures++;
      $display("FAIL clr_summary got done=%b writes=%0d busy_acks=%0d exp done=1 writes=8192 acks=0",
               done_seen, ca, acks_busy);
    end
    for (int i = 0; i < 8192; i++) shadow[i] = 16'h0700;
    shadow[13'h0050] = 16'h1111;
    n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (host_ack) got = 1;
      if (clear_done) dones++;
      @(posedge clk); #1;
      n++;
    end
    host_req = 1'b0; host_we = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (clear_done || host_busy) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (!got || dones != 1) begin
      failures++;
      $display("FAIL clr_after got ack=%b done/busy events=%0d exp ack=1 events=1", got, dones);
    end
    host_read(13'h1234, d, got);
    checks++;
    if (!got || d !== 16'h0700) begin
      failures++;
      $display("FAIL clr_readback got=%h ack=%b exp=0700", d, got);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_display();
    test_back_to_back();
    test_fifo_full();
    test_raw();
    test_read_collision();
    test_reset_mid_read();
`ifdef TEXT_VMEM_CLEAR_EN
    test_clear();
`endif
    repeat (5) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending writes exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
